// File: rtl/add_round_key_nb.sv
// add_round_key_nb
//   Walks an NB-column AES-style state held in a dual-port RAM and XORs
//   every byte with the matching byte of round key n, fetched one column at
//   a time from a round-key RAM. Only bits [7:0] of each state element carry
//   data; bits [DW-1:8] are written back as zero.
//
//   Column schedule (4 cycles per column, one CHK entry per column):
//     CHK  : read rows 0/1 and the key column
//     RD_A : capture rows 0/1 + key, read rows 2/3
//     WR_A : write rows 0/1 while rows 2/3 arrive on q0/q1 and get captured
//     WR_B : write rows 2/3, advance to the next column
//   RD_B is kept in the encoding but the loop never enters it: its capture
//   is folded into WR_A so that both RAM ports are busy every cycle of a
//   column. This gives ap_done exactly 1+4*NB cycles after start is taken.
//
//   Optional build macro: ADD_ROUND_KEY_LOCK_EN adds the working_key port and
//   the LOCK_KEY parameter. A working_key different from LOCK_KEY folds
//   working_key[7:0] into every written byte and flips the key column index
//   with working_key[8].
//
// Ports
//   ap_clk, ap_rst_n             clock, synchronous active-low reset
//   ap_start/done/idle/ready     block-level handshake (done/ready pulse)
//   n                            round index, sampled when start is taken
//   statemt_*0 / statemt_*1      dual-port state RAM, 1-cycle read latency
//   key_address/key_ce/key_q     round-key RAM, key_q = {row3,row2,row1,row0}
//   ap_err                       one-cycle pulse for an out-of-range n
//   working_key                  (ADD_ROUND_KEY_LOCK_EN only) unlock word
module add_round_key_nb #(
  parameter int NB         = 4,
  parameter int DW         = 32,
  parameter int MAX_ROUNDS = 14,
`ifdef ADD_ROUND_KEY_LOCK_EN
  parameter logic [15:0] LOCK_KEY = 16'h5A3C,
`endif
  localparam int SAW = $clog2(4 * NB),
  localparam int KAW = $clog2((MAX_ROUNDS + 1) * NB)
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           ap_start,
  output logic           ap_done,
  output logic           ap_idle,
  output logic           ap_ready,
  input  logic [3:0]     n,
  output logic [SAW-1:0] statemt_address0,
  output logic           statemt_ce0,
  output logic           statemt_we0,
  output logic [DW-1:0]  statemt_d0,
  input  logic [DW-1:0]  statemt_q0,
  output logic [SAW-1:0] statemt_address1,
  output logic           statemt_ce1,
  output logic           statemt_we1,
  output logic [DW-1:0]  statemt_d1,
  input  logic [DW-1:0]  statemt_q1,
  output logic [KAW-1:0] key_address,
  output logic           key_ce,
  input  logic [31:0]    key_q,
  output logic           ap_err
`ifdef ADD_ROUND_KEY_LOCK_EN
  ,
  input  logic [15:0]    working_key
`endif
);

  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(NB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_RD_A,
    S_RD_B,
    S_WR_A,
    S_WR_B
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [3:0]      n_r_q, n_r_d;
  logic [7:0]      elem0_q, elem0_d;
  logic [7:0]      elem1_q, elem1_d;
  logic [7:0]      elem2_q, elem2_d;
  logic [7:0]      elem3_q, elem3_d;
  logic [31:0]     key_word_q, key_word_d;

  logic [7:0]      xor_extra;
  logic            col_flip;
  logic [CW-1:0]   key_col;
  logic [31:0]     col_base;

  // Upper bits of the read data never reach the output.
  logic            unused_q_hi;
  assign unused_q_hi = ^{statemt_q0[DW-1:8], statemt_q1[DW-1:8]};

`ifdef ADD_ROUND_KEY_LOCK_EN
  // A wrong working key silently corrupts the result instead of stalling.
  logic lock_miss;
  assign lock_miss = (working_key != LOCK_KEY);
  assign xor_extra = lock_miss ? working_key[7:0] : 8'h00;
  assign col_flip  = lock_miss & working_key[8];
`else
  assign xor_extra = 8'h00;
  assign col_flip  = 1'b0;
`endif

  assign key_col  = col_q ^ {{(CW-1){1'b0}}, col_flip};
  assign col_base = 32'(col_q) * 32'd4;

  function automatic logic [DW-1:0] mix(input logic [7:0] elem,
                                        input logic [7:0] kb,
                                        input logic [7:0] extra);
    return {{(DW-8){1'b0}}, elem ^ kb ^ extra};
  endfunction

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      n_r_q      <= '0;
      elem0_q    <= '0;
      elem1_q    <= '0;
      elem2_q    <= '0;
      elem3_q    <= '0;
      key_word_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      n_r_q      <= n_r_d;
      elem0_q    <= elem0_d;
      elem1_q    <= elem1_d;
      elem2_q    <= elem2_d;
      elem3_q    <= elem3_d;
      key_word_q <= key_word_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    col_d            = col_q;
    n_r_d            = n_r_q;
    elem0_d          = elem0_q;
    elem1_d          = elem1_q;
    elem2_d          = elem2_q;
    elem3_d          = elem3_q;
    key_word_d       = key_word_q;
    ap_done          = 1'b0;
    ap_idle          = 1'b0;
    ap_ready         = 1'b0;
    ap_err           = 1'b0;
    statemt_address0 = '0;
    statemt_address1 = '0;
    statemt_ce0      = 1'b0;
    statemt_ce1      = 1'b0;
    statemt_we0      = 1'b0;
    statemt_we1      = 1'b0;
    statemt_d0       = '0;
    statemt_d1       = '0;
    key_address      = '0;
    key_ce           = 1'b0;

    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          n_r_d   = n;
          col_d   = '0;
          state_d = S_CHK;
        end
      end

      S_CHK: begin
        if (32'(n_r_q) > MAX_ROUNDS) begin
          ap_err   = 1'b1;
          ap_done  = 1'b1;
          ap_ready = 1'b1;
          state_d  = S_IDLE;
        end else if (col_q == LAST_COL) begin
          ap_done  = 1'b1;
          ap_ready = 1'b1;
          state_d  = S_IDLE;
        end else begin
          statemt_ce0      = 1'b1;
          statemt_ce1      = 1'b1;
          statemt_address0 = SAW'(col_base);
          statemt_address1 = SAW'(col_base + 32'd1);
          key_ce           = 1'b1;
          key_address      = KAW'(32'(n_r_q) * 32'(NB) + 32'(key_col));
          state_d          = S_RD_A;
        end
      end

      S_RD_A: begin
        elem0_d          = statemt_q0[7:0];
        elem1_d          = statemt_q1[7:0];
        key_word_d       = key_q;
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_address0 = SAW'(col_base + 32'd2);
        statemt_address1 = SAW'(col_base + 32'd3);
        state_d          = S_WR_A;
      end

      S_WR_A: begin
        // Rows 2/3 read in RD_A are on q0/q1 now; grab them while writing 0/1.
        elem2_d          = statemt_q0[7:0];
        elem3_d          = statemt_q1[7:0];
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_we0      = 1'b1;
        statemt_we1      = 1'b1;
        statemt_address0 = SAW'(col_base);
        statemt_address1 = SAW'(col_base + 32'd1);
        statemt_d0       = mix(elem0_q, key_word_q[7:0], xor_extra);
        statemt_d1       = mix(elem1_q, key_word_q[15:8], xor_extra);
        state_d          = S_WR_B;
      end

      S_WR_B: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_we0      = 1'b1;
        statemt_we1      = 1'b1;
        statemt_address0 = SAW'(col_base + 32'd2);
        statemt_address1 = SAW'(col_base + 32'd3);
        statemt_d0       = mix(elem2_q, key_word_q[23:16], xor_extra);
        statemt_d1       = mix(elem3_q, key_word_q[31:24], xor_extra);
        col_d            = col_q + CW'(1);
        state_d          = S_CHK;
      end

      // Not on the column path; fall back to a clean idle if ever reached.
      S_RD_B:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
